// File: rtl/norm2_pkg.sv
// Shared types and sizes for the norm2 scheduler.
package norm2_pkg;
    localparam int DEPTH = 1000;
    localparam int AW    = 10;
    localparam int DW    = 27;
    localparam int RW    = 64;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        START = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } norm2_state_t;

    typedef logic signed [DW-1:0] elem_t;
    typedef logic [RW-1:0]        result_t;
endpackage

// File: rtl/norm2_wdt.sv
// RUN-cycle watchdog: counts enabled cycles since the last clear and flags
// the cycle in which the count sits at WDT_CYCLES-1.
module norm2_wdt #(
    parameter int WDT_CYCLES = 16384
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(WDT_CYCLES) + 1;

    logic [CW-1:0] cnt;

    // Cycle counter; saturates at the limit so it never wraps while waiting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && !expired)
            cnt <= cnt + 1'b1;
    end

    assign expired = en && (cnt == CW'(WDT_CYCLES - 1));
endmodule

// File: rtl/norm2_sched.sv
// Scheduler / port owner for the norm2 sum-of-squares kernel.
// Optional watchdog abort is compiled in with NORM2_SCHED_WDT_EN.
module norm2_sched
    import norm2_pkg::*;
#(
    parameter int DEPTH      = norm2_pkg::DEPTH,
    parameter int AW         = norm2_pkg::AW,
    parameter int DW         = norm2_pkg::DW,
    parameter int RW         = norm2_pkg::RW,
    parameter int WDT_CYCLES = 16384
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [RW-1:0] out_data,
    output logic          err,
    output logic          busy,
    output logic          k_r_enable,
    output logic          k_control_arr,
    output logic [RW-1:0] k_init_i,
    output logic [RW-1:0] k_init_acc,
    output logic          k_we,
    output logic [AW-1:0] k_addr,
    output logic [DW-1:0] k_wdata,
    input  logic [DW-1:0] k_rdata,
    input  logic          k_w_enable,
    input  logic [RW-1:0] k_result
);
    norm2_state_t  state;
    logic [AW-1:0] addr;
    logic          wdt_expired;

    // Array read data is reserved; fold it away so it has a sink.
    logic unused_rdata;
    assign unused_rdata = ^k_rdata;

`ifdef NORM2_SCHED_WDT_EN
    // Clear during START so the count starts at 0 on the first RUN cycle.
    norm2_wdt #(.WDT_CYCLES(WDT_CYCLES)) u_wdt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == START),
        .en      (state == RUN),
        .expired (wdt_expired)
    );
`else
    localparam int unused_wdt_cycles = WDT_CYCLES;
    assign wdt_expired = 1'b0;
`endif

    // Scheduler FSM, address counter and result/err capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= LOAD;
            addr     <= '0;
            out_data <= '0;
            err      <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        if (addr == AW'(DEPTH - 1)) begin
                            addr  <= '0;
                            state <= START;
                        end else begin
                            addr <= addr + 1'b1;
                        end
                    end
                end
                START: state <= RUN;
                RUN: begin
                    // A real completion wins over a simultaneous expiry.
                    if (k_w_enable) begin
                        out_data <= k_result;
                        err      <= 1'b0;
                        state    <= DONE;
                    end else if (wdt_expired) begin
                        out_data <= '0;
                        err      <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        err   <= 1'b0;
                        state <= LOAD;
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    // Port decode straight off the state register.
    assign in_ready      = (state == LOAD);
    assign k_control_arr = (state == LOAD);
    assign k_we          = (state == LOAD) && in_valid;
    assign k_addr        = addr;
    assign k_wdata       = in_data;
    assign k_r_enable    = (state != RUN);
    assign busy          = (state == START) || (state == RUN);
    assign out_valid     = (state == DONE);
    assign k_init_i      = '0;
    assign k_init_acc    = '0;
endmodule

// File: tb/tb_norm2_sched.sv
// Directed bench for norm2_sched with a behavioural kernel/array stub.
module tb_norm2_sched;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [26:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] out_data;
    logic        err;
    logic        busy;
    logic        k_r_enable;
    logic        k_control_arr;
    logic [63:0] k_init_i;
    logic [63:0] k_init_acc;
    logic        k_we;
    logic [9:0]  k_addr;
    logic [26:0] k_wdata;
    logic [26:0] k_rdata;
    logic        k_w_enable;
    logic [63:0] k_result;

    int total = 0;
    int bad = 0;

    norm2_sched #(.WDT_CYCLES(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .err(err), .busy(busy),
        .k_r_enable(k_r_enable), .k_control_arr(k_control_arr),
        .k_init_i(k_init_i), .k_init_acc(k_init_acc),
        .k_we(k_we), .k_addr(k_addr), .k_wdata(k_wdata), .k_rdata(k_rdata),
        .k_w_enable(k_w_enable), .k_result(k_result)
    );

    always #5 clk = ~clk;

    // Kernel stub: array written through the control port; when released
    // it raises w_enable a few cycles later with the sum of squares.
    logic signed [26:0] mem [1000];
    int  kcnt;
    bit  stub_dead = 1'b0;
    assign k_rdata = mem[k_addr];

    always @(posedge clk) begin
        longint s;
        if (k_we && k_control_arr) mem[k_addr] <= k_wdata;
        if (k_r_enable) begin
            k_w_enable <= 1'b0;
            kcnt       <= 0;
        end else begin
            kcnt <= kcnt + 1;
            if (kcnt == 5 && !stub_dead) begin
                s = 0;
                for (int i = 0; i < 1000; i++) s += longint'(mem[i]) * longint'(mem[i]);
                k_result   <= 64'(s);
                k_w_enable <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int we_err;
    int last_addr;

    // Push n accepted elements; mode 0 = constant v, mode 1 = index mod 7.
    task automatic push(input int n, input int mode, input logic [26:0] v, input bit gaps);
        int acc = 0;
        int guard = 0;
        while (acc < n && guard < 5000) begin
            @(negedge clk);
            guard++;
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = (mode == 1) ? 27'(acc % 7) : v;
            #1;
            if (k_we !== in_valid) we_err++;
            if (in_valid && in_ready) begin
                last_addr = int'(k_addr);
                acc++;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        if (acc < n) chk("push_timeout", 64'(acc), 64'(n));
    endtask

    // Wait (bounded) for out_valid at a negedge.
    task automatic wait_out(input string tag);
        int c = 0;
        while (!out_valid && c < 500) begin
            @(negedge clk);
            c++;
        end
        chk(tag, 64'(out_valid), 64'd1);
    endtask

    int run_cycles;
    int hold_err;
    logic [63:0] held;

    initial begin
        // Reset state
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_r_enable", 64'(k_r_enable), 64'd1);
        chk("rst_ctrl_arr", 64'(k_control_arr), 64'd1);
        chk("rst_k_addr", 64'(k_addr), 64'd0);
        chk("rst_k_we", 64'(k_we), 64'd0);
        #20 rst_n = 1'b1;

        // 1000 x (+1), no gaps; then check START/RUN decode
        push(1000, 0, 27'd1, 1'b0);
        // push ended one negedge after the last accept: now in START
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_ctrl_arr", 64'(k_control_arr), 64'd0);
        chk("start_r_enable", 64'(k_r_enable), 64'd1);
        @(negedge clk);
        chk("run_r_enable", 64'(k_r_enable), 64'd0);
        chk("run_in_ready", 64'(in_ready), 64'd0);
        wait_out("ones_valid");
        chk("ones_data", out_data, 64'd1000);
        chk("ones_err", 64'(err), 64'd0);
        chk("ones_init_i", k_init_i | k_init_acc, 64'd0);
        @(negedge clk);
        chk("ones_back_load", 64'(in_ready), 64'd1);
        chk("ones_valid_drop", 64'(out_valid), 64'd0);

        // 1000 x (-3) with gaps
        we_err = 0;
        push(1000, 0, 27'h7FFFFFD, 1'b1);
        chk("m3_last_addr", 64'(last_addr), 64'd999);
        chk("m3_we_pulses", 64'(we_err), 64'd0);
        wait_out("m3_valid");
        chk("m3_data", out_data, 64'd9000);

        // 1000 x (-2^26), hold out_ready low for 10 cycles in DONE
        @(negedge clk);
        out_ready = 1'b0;
        push(1000, 0, 27'h4000000, 1'b0);
        wait_out("big_valid");
        chk("big_data", out_data, 64'd4503599627370496000);
        held = out_data;
        hold_err = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || k_r_enable !== 1'b1)
                hold_err++;
        end
        chk("hold_stable", 64'(hold_err), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("hold_release", 64'(in_ready), 64'd1);

        // Reset after 500 accepts, then a full mod-7 load
        push(500, 0, 27'd5, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_k_addr", 64'(k_addr), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        #10 rst_n = 1'b1;
        push(1000, 1, 27'd0, 1'b0);
        wait_out("mod7_valid");
        chk("mod7_data", out_data, 64'd12977);
        @(negedge clk);

`ifdef NORM2_SCHED_WDT_EN
        // Kernel that never finishes: watchdog abort after 64 RUN cycles
        stub_dead = 1'b1;
        push(1000, 0, 27'd1, 1'b0);
        run_cycles = 0;
        for (int i = 0; i < 300 && !out_valid; i++) begin
            if (!k_r_enable) run_cycles++;
            @(negedge clk);
        end
        chk("wdt_valid", 64'(out_valid), 64'd1);
        chk("wdt_err", 64'(err), 64'd1);
        chk("wdt_data", out_data, 64'd0);
        chk("wdt_run_cycles", 64'(run_cycles), 64'd64);
        @(negedge clk);
        chk("wdt_err_clear", 64'(err), 64'd0);
        stub_dead = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
